lsu_dmem_master: RTL and testbench

LSU_DMEM_MASTER -- requirements
Module: lsu_dmem_master

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_load_align.sv | 44 ++++
 rtl/lsu_dmem_master.sv | 181 ++++++++++++++++++
 tb/tb_lsu_dmem_master.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU data-memory master.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic logic [63:0] expand_byte_mask(input logic [7:0] byte_mask);
    logic [63:0] bit_mask;
    bit_mask = 64'd0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{byte_mask[i]}};
    end
    return bit_mask;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load datapath: merges the one or two RAM beats into a right-aligned value,
// then truncates to the access size and sign/zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic        second_beat,
  input  logic [63:0] acc_in,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] acc_out,
  output logic [63:0] result
);

  logic [6:0] lo_shift;
  logic [6:0] hi_shift;

  assign lo_shift = {1'b0, offset, 3'b000};
  assign hi_shift = 7'd64 - lo_shift;

  // Beat merge: the second beat supplies the bytes above the first beat's.
  always_comb begin
    if (second_beat) begin
      acc_out = acc_in | (rdata << hi_shift);
    end else begin
      acc_out = rdata >> lo_shift;
    end
  end

  // Size truncation and extension.
  always_comb begin
    case (size)
      SZ_B:    result = is_unsigned ? {56'd0, acc_out[7:0]}
                                    : {{56{acc_out[7]}}, acc_out[7:0]};
      SZ_H:    result = is_unsigned ? {48'd0, acc_out[15:0]}
                                    : {{48{acc_out[15]}}, acc_out[15:0]};
      SZ_W:    result = is_unsigned ? {32'd0, acc_out[31:0]}
                                    : {{32{acc_out[31]}}, acc_out[31:0]};
      default: result = acc_out;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_master.sv
// LSU master for a 64-bit data RAM port: one access at a time, optionally
// splitting accesses that cross an 8-byte boundary into two beats.
module lsu_dmem_master
  import lsu_pkg::*;
#(
  parameter int SPLIT_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        dmem_en,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [63:0] dmem_wmask,
  output logic        dmem_wen,
  input  logic [63:0] dmem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [2:0]  off_s;
  logic [3:0]  nbytes_s;
  logic        cross_s;
  logic        reject_s;
  logic [63:0] base_addr_s;
  logic [7:0]  bm_full_s;
  logic [7:0]  bm_beat0_s;
  logic [7:0]  bm_beat1_s;
  logic [63:0] acc_next_s;
  logic [63:0] load_result_s;

  assign off_s       = addr_q[2:0];
  assign nbytes_s    = 4'd1 << size_q;
  assign cross_s     = ({1'b0, off_s} + nbytes_s) > 4'd8;
  assign reject_s    = cross_s && (SPLIT_EN == 0);
  assign base_addr_s = {addr_q[63:3], 3'b000};
  assign bm_full_s   = 8'((9'd1 << nbytes_s) - 9'd1);
  assign bm_beat0_s  = bm_full_s << off_s;
  assign bm_beat1_s  = bm_full_s >> (4'd8 - {1'b0, off_s});

  lsu_load_align u_load_align (
    .rdata       (dmem_rdata),
    .offset      (off_s),
    .second_beat (state_q == ST_BEAT1),
    .acc_in      (acc_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .acc_out     (acc_next_s),
    .result      (load_result_s)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // RAM port drive; rst gates enables directly so an aborted store never writes.
  always_comb begin
    dmem_en    = 1'b0;
    dmem_wen   = 1'b0;
    dmem_addr  = 64'd0;
    dmem_wdata = 64'd0;
    dmem_wmask = 64'd0;
    if (!rst && (state_q == ST_BEAT0) && !reject_s) begin
      dmem_en    = 1'b1;
      dmem_wen   = wen_q;
      dmem_addr  = base_addr_s;
      dmem_wdata = wen_q ? (wdata_q << {off_s, 3'b000}) : 64'd0;
      dmem_wmask = wen_q ? expand_byte_mask(bm_beat0_s) : 64'd0;
    end else if (!rst && (state_q == ST_BEAT1)) begin
      dmem_en    = 1'b1;
      dmem_wen   = wen_q;
      dmem_addr  = base_addr_s + 64'd8;
      dmem_wdata = wen_q ? (wdata_q >> (7'd64 - {1'b0, off_s, 3'b000})) : 64'd0;
      dmem_wmask = wen_q ? expand_byte_mask(bm_beat1_s) : 64'd0;
    end else begin
      dmem_en    = 1'b0;
      dmem_wen   = 1'b0;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    wdata_d      = wdata_q;
    acc_d        = acc_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          wen_d      = req_wen;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          wdata_d    = req_wdata;
          acc_d      = 64'd0;
          state_d    = ST_BEAT0;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_BEAT0: begin
        if (reject_s) begin
          resp_rdata_d = 64'd0;
          resp_err_d   = 1'b1;
          state_d      = ST_RESP;
        end else if (cross_s) begin
          acc_d        = acc_next_s;
          state_d      = ST_BEAT1;
        end else begin
          resp_rdata_d = wen_q ? 64'd0 : load_result_s;
          resp_err_d   = 1'b0;
          state_d      = ST_RESP;
        end
      end
      ST_BEAT1: begin
        acc_d        = acc_next_s;
        resp_rdata_d = wen_q ? 64'd0 : load_result_s;
        resp_err_d   = 1'b0;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= 64'd0;
      wen_q        <= 1'b0;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      wdata_q      <= 64'd0;
      acc_q        <= 64'd0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      wdata_q      <= wdata_d;
      acc_q        <= acc_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master: split instance backed by a small RAM
// model, plus a non-split instance for the rejection path.
module tb_lsu_dmem_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_init = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        u_req_valid = 1'b0, u_req_ready, u_req_wen = 1'b0, u_req_unsigned = 1'b0;
  logic [63:0] u_req_addr = 64'd0, u_req_wdata = 64'd0;
  logic [1:0]  u_req_size = 2'd0;
  logic        u_resp_valid, u_resp_ready = 1'b1, u_resp_err;
  logic [63:0] u_resp_rdata;
  logic        u_dmem_en, u_dmem_wen;
  logic [63:0] u_dmem_addr, u_dmem_wdata, u_dmem_wmask, u_dmem_rdata;

  logic        n_req_valid = 1'b0, n_req_ready, n_req_wen = 1'b0, n_req_unsigned = 1'b0;
  logic [63:0] n_req_addr = 64'd0, n_req_wdata = 64'd0;
  logic [1:0]  n_req_size = 2'd0;
  logic        n_resp_valid, n_resp_ready = 1'b0, n_resp_err;
  logic [63:0] n_resp_rdata;
  logic        n_dmem_en, n_dmem_wen;
  logic [63:0] n_dmem_addr, n_dmem_wdata, n_dmem_wmask;
  logic [63:0] n_dmem_rdata = 64'h0123_4567_89AB_CDEF;

  lsu_dmem_master #(.SPLIT_EN(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(u_req_valid), .req_ready(u_req_ready), .req_addr(u_req_addr),
    .req_wen(u_req_wen), .req_size(u_req_size), .req_unsigned(u_req_unsigned),
    .req_wdata(u_req_wdata), .resp_valid(u_resp_valid), .resp_ready(u_resp_ready),
    .resp_rdata(u_resp_rdata), .resp_err(u_resp_err), .dmem_en(u_dmem_en),
    .dmem_addr(u_dmem_addr), .dmem_wdata(u_dmem_wdata), .dmem_wmask(u_dmem_wmask),
    .dmem_wen(u_dmem_wen), .dmem_rdata(u_dmem_rdata)
  );

  lsu_dmem_master #(.SPLIT_EN(0)) n_dut (
    .clk(clk), .rst(rst),
    .req_valid(n_req_valid), .req_ready(n_req_ready), .req_addr(n_req_addr),
    .req_wen(n_req_wen), .req_size(n_req_size), .req_unsigned(n_req_unsigned),
    .req_wdata(n_req_wdata), .resp_valid(n_resp_valid), .resp_ready(n_resp_ready),
    .resp_rdata(n_resp_rdata), .resp_err(n_resp_err), .dmem_en(n_dmem_en),
    .dmem_addr(n_dmem_addr), .dmem_wdata(n_dmem_wdata), .dmem_wmask(n_dmem_wmask),
    .dmem_wen(n_dmem_wen), .dmem_rdata(n_dmem_rdata)
  );

  // RAM model: 16 words from 0x8000_0000, combinational read, masked write.
  logic [63:0] mem [16];
  assign u_dmem_rdata = mem[u_dmem_addr[6:3]];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 64'd0;
      mem[0] <= 64'h8000_0000_9C00_0000;
      mem[1] <= 64'h0000_0000_0000_00FF;
    end else if (u_dmem_en && u_dmem_wen) begin
      mem[u_dmem_addr[6:3]] <= (mem[u_dmem_addr[6:3]] & ~u_dmem_wmask)
                             | (u_dmem_wdata & u_dmem_wmask);
    end
  end

  logic [63:0] b_addr [$];
  logic [63:0] b_wdata [$];
  logic [63:0] b_wmask [$];
  logic        b_wen [$];
  int          n_en_count = 0;

  always @(negedge clk) begin
    if (u_dmem_en) begin
      b_addr.push_back(u_dmem_addr);
      b_wdata.push_back(u_dmem_wdata);
      b_wmask.push_back(u_dmem_wmask);
      b_wen.push_back(u_dmem_wen);
    end
    if (n_dmem_en) n_en_count++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access on the split instance; returns at the negedge where resp_valid is seen.
  task automatic u_access(input logic [63:0] a, input logic w, input logic [1:0] sz,
                          input logic un, input logic [63:0] wd, output int lat);
    b_addr.delete(); b_wdata.delete(); b_wmask.delete(); b_wen.delete();
    @(negedge clk);
    u_req_valid = 1'b1; u_req_addr = a; u_req_wen = w;
    u_req_size = sz; u_req_unsigned = un; u_req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    check("busy_ready_low", {63'd0, u_req_ready}, 64'd0);
    u_req_valid = 1'b0;
    while (!u_resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ram_init = 1'b0;
    @(negedge clk);

    check("rst_req_ready", {63'd0, u_req_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, u_resp_valid}, 64'd0);
    check("rst_resp_rdata", u_resp_rdata, 64'd0);
    check("rst_resp_err", {63'd0, u_resp_err}, 64'd0);
    check("rst_dmem_ctl", {62'd0, u_dmem_en, u_dmem_wen}, 64'd0);
    check("rst_dmem_addr", u_dmem_addr, 64'd0);
    check("rst_dmem_wdata", u_dmem_wdata, 64'd0);
    check("rst_dmem_wmask", u_dmem_wmask, 64'd0);

    // Split signed halfword load across words 0/1.
    u_access(64'h8000_0007, 1'b0, 2'd1, 1'b0, 64'd0, lat);
    check("ld_h_lat", 64'(lat), 64'd3);
    check("ld_h_rdata", u_resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    check("ld_h_err", {63'd0, u_resp_err}, 64'd0);
    check("ld_h_nbeats", 64'(b_addr.size()), 64'd2);
    if (b_addr.size() == 2) begin
      check("ld_h_addr0", b_addr[0], 64'h8000_0000);
      check("ld_h_addr1", b_addr[1], 64'h8000_0008);
      check("ld_h_wen0", {63'd0, b_wen[0]}, 64'd0);
    end

    u_access(64'h8000_0003, 1'b0, 2'd0, 1'b1, 64'd0, lat);
    check("ld_bu_lat", 64'(lat), 64'd2);
    check("ld_bu_rdata", u_resp_rdata, 64'h0000_0000_0000_009C);

    u_access(64'h8000_0003, 1'b0, 2'd0, 1'b0, 64'd0, lat);
    check("ld_b_rdata", u_resp_rdata, 64'hFFFF_FFFF_FFFF_FF9C);

    // Aligned doubleword store.
    u_access(64'h8000_0010, 1'b1, 2'd3, 1'b0, 64'h1122_3344_5566_7788, lat);
    check("st_d_lat", 64'(lat), 64'd2);
    check("st_d_rdata", u_resp_rdata, 64'd0);
    check("st_d_nbeats", 64'(b_addr.size()), 64'd1);
    if (b_addr.size() == 1) begin
      check("st_d_addr", b_addr[0], 64'h8000_0010);
      check("st_d_wmask", b_wmask[0], 64'hFFFF_FFFF_FFFF_FFFF);
      check("st_d_wdata", b_wdata[0], 64'h1122_3344_5566_7788);
    end
    @(negedge clk);
    check("st_d_mem", mem[2], 64'h1122_3344_5566_7788);

    // Split word store at offset 6.
    u_access(64'h8000_0006, 1'b1, 2'd2, 1'b0, 64'h0000_0000_AABB_CCDD, lat);
    check("st_w_lat", 64'(lat), 64'd3);
    check("st_w_nbeats", 64'(b_addr.size()), 64'd2);
    if (b_addr.size() == 2) begin
      check("st_w_addr0", b_addr[0], 64'h8000_0000);
      check("st_w_wmask0", b_wmask[0], 64'hFFFF_0000_0000_0000);
      check("st_w_wdata0", b_wdata[0], 64'hCCDD_0000_0000_0000);
      check("st_w_addr1", b_addr[1], 64'h8000_0008);
      check("st_w_wmask1", b_wmask[1], 64'h0000_0000_0000_FFFF);
      check("st_w_wdata1", b_wdata[1], 64'h0000_0000_0000_AABB);
    end
    @(negedge clk);
    check("st_w_mem0", mem[0], 64'hCCDD_0000_9C00_0000);
    check("st_w_mem1", mem[1], 64'h0000_0000_0000_AABB);

    // Non-split instance rejects a crossing doubleword load and holds it.
    n_en_count = 0;
    @(negedge clk);
    n_req_valid = 1'b1; n_req_addr = 64'h8000_0004; n_req_size = 2'd3;
    n_req_wen = 1'b0; n_req_unsigned = 1'b0; n_resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_req_valid = 1'b0;
    lat = 1;
    while (!n_resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("rej_lat", 64'(lat), 64'd2);
    check("rej_err", {63'd0, n_resp_err}, 64'd1);
    check("rej_rdata", n_resp_rdata, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rej_hold", {62'd0, n_resp_valid, n_resp_err}, 64'd3);
    end
    n_resp_ready = 1'b1;
    @(negedge clk);
    check("rej_released", {62'd0, n_resp_valid, n_req_ready}, 64'd1);
    check("rej_no_en", 64'(n_en_count), 64'd0);

    // Reset during BEAT0 of a store aborts the write.
    @(negedge clk);
    u_req_valid = 1'b1; u_req_addr = 64'h8000_0020; u_req_wen = 1'b1;
    u_req_size = 2'd3; u_req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    u_req_valid = 1'b0;
    check("abort_beat0_en", {63'd0, u_dmem_en}, 64'd1);
    rst = 1'b1;
    #1;
    check("abort_gated", {62'd0, u_dmem_en, u_dmem_wen}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", {62'd0, u_req_ready, u_resp_valid}, 64'd2);
    check("abort_no_write", mem[4], 64'd0);

    u_access(64'h8000_0010, 1'b0, 2'd3, 1'b0, 64'd0, lat);
    check("post_rst_lat", 64'(lat), 64'd2);
    check("post_rst_rdata", u_resp_rdata, 64'h1122_3344_5566_7788);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
